// File: rtl/sd4_align_accumulator.sv
// Aligning accumulator for the SD4 MAC datapath: absorbs signed mantissa/exponent
// terms against a running maximum exponent and presents each closed group to normalization.
module sd4_align_accumulator #(
  parameter int PW        = 12,
  parameter int MAX_TERMS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_mant,
  input  logic [5:0]    in_exp,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [19:0]   signed_sum,
  output logic [5:0]    exp_max,
  output logic          err_len
);

  localparam int AW = 20;
  localparam int CW = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  state_t                r_state;
  logic signed [AW-1:0]  r_acc;
  logic signed [5:0]     r_acc_exp;
  logic [CW-1:0]         r_cnt;
  logic [AW-1:0]         r_sum;
  logic [5:0]            r_exp;
  logic                  r_err;
  logic                  r_in_ready;
  logic                  r_out_valid;

  logic                  w_accept;
  logic                  w_first;
  logic signed [AW-1:0]  w_mant_ext;
  logic [6:0]            w_d;
  logic                  w_d_pos;
  logic [6:0]            w_shamt;
  logic signed [AW-1:0]  w_acc_next;
  logic signed [5:0]     w_exp_next;
  logic [CW-1:0]         w_cnt_next;
  logic                  w_full;
  logic                  w_close;

  // Arithmetic right shift that saturates to pure sign fill once the
  // shift amount reaches the accumulator width.
  function automatic logic signed [AW-1:0] shr(input logic signed [AW-1:0] x,
                                               input logic [6:0] n);
    if (n >= 7'(AW)) return {AW{x[AW-1]}};
    return x >>> n;
  endfunction

  assign w_accept   = in_valid && r_in_ready;
  assign w_first    = (r_state == S_IDLE);
  assign w_mant_ext = {{(AW-PW){in_mant[PW-1]}}, in_mant};
  assign w_d        = {in_exp[5], in_exp} - {r_acc_exp[5], r_acc_exp};
  assign w_d_pos    = !w_d[6] && (w_d != '0);
  assign w_shamt    = w_d_pos ? w_d : (7'd0 - w_d);

  always_comb begin
    w_acc_next = '0;
    w_exp_next = r_acc_exp;
    w_cnt_next = r_cnt + CW'(1);
    if (w_first) begin
      w_acc_next = w_mant_ext;
      w_exp_next = $signed(in_exp);
      w_cnt_next = CW'(1);
    end else if (w_d_pos) begin
      w_acc_next = shr(r_acc, w_shamt) + w_mant_ext;
      w_exp_next = $signed(in_exp);
    end else begin
      w_acc_next = r_acc + shr(w_mant_ext, w_shamt);
    end
  end

  assign w_full  = (w_cnt_next == CW'(MAX_TERMS));
  assign w_close = in_last || w_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_acc_exp   <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_exp       <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_accept) begin
            r_acc     <= w_acc_next;
            r_acc_exp <= w_exp_next;
            r_cnt     <= w_cnt_next;
            if (w_close) begin
              r_state     <= S_HOLD;
              r_sum       <= w_acc_next;
              r_exp       <= w_exp_next;
              r_err       <= !in_last;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_sum       <= '0;
            r_exp       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign signed_sum = r_sum;
  assign exp_max    = r_exp;
  assign err_len    = r_err;

endmodule
